calc1_port_responder: RTL and testbench
=======================================

// Module: calc1_port_responder
// PURPOSE
//  Responder (server) side of a single calc1 request/response port; the stimulus driver is the requester.
//  Accepts one command plus two 32-bit operands, computes the result and returns one response word and code.
//  Serves as a golden single-port engine for the calc1 bench and as the per-port slice of a reduced calc1 core.
// PARAMETERS
//  LATENCY  3  cycles from operand-2 capture to response cycle; legal range 1..15
// PORTS
//  c_clk         in   1     single clock; all sampling on rising edge
//  reset         in   1     asynchronous, active-low reset (0 = in reset)
//  req_cmd_in    in   [0:3] command: 0 nop, 1 add, 2 sub, 5 shl, 6 shr, others invalid
//  req_data_in   in   [0:31] operand 1 in command cycle, operand 2 in following cycle
//  out_resp      out  [0:1] 0 none, 1 success, 2 overflow/underflow, 3 invalid command
//  out_data      out  [0:31] result; valid only when out_resp==1
//  busy          out  1     high from command acceptance through the response cycle
//  cmd_dropped   out  1     one-cycle pulse: nonzero cmd seen while busy and not accepted
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE, out_resp=0, out_data=0, busy=0, cmd_dropped=0, latency counter=0.
//  FSM states: IDLE -> OP2 -> EXEC -> RESP -> IDLE.
//   IDLE: if req_cmd_in!=0, latch cmd and op1=req_data_in, go OP2; else stay.
//   OP2 : latch op2=req_data_in unconditionally (req_cmd_in ignored); load counter=LATENCY-1; go EXEC.
//   EXEC: if counter==0 go RESP, else decrement.
//   RESP: drive out_resp/out_data for exactly this one cycle; go IDLE.
//  Timing: cmd accepted in cycle T -> op2 in T+1 -> response in cycle T+1+LATENCY.
//  Outside RESP: out_resp=0 and out_data=0 (registered outputs, no glitches).
//  busy=1 in OP2, EXEC and RESP; a new command can be accepted in the cycle after RESP at the earliest.
//  Nonzero req_cmd_in in EXEC or RESP: ignored, cmd_dropped=1 next cycle; OP2 never flags (data cycle).
//  Arithmetic, unsigned 32-bit, bit 0 = MSB:
//   add: 33-bit sum; carry-out -> resp 2, data 0; else resp 1, data = sum[1:32].
//   sub: op2>op1 -> resp 2, data 0; else resp 1, data = op1-op2 (op1==op2 gives 0, resp 1).
//   shl/shr: shift count = op2[27:31] (0..31), zero fill, never overflows; resp 1.
//   Invalid cmd (3,4,7..15): op2 still consumed, same timing, resp 3, data 0.
//  Reset asserted mid-operation: transaction abandoned, no response ever issued for it.
//  LATENCY outside 1..15: elaboration error via generate-time check.
// TESTING
//  add 0x00000005 + 0x00000007 at T -> resp 1, data 0x0000000C at T+4 (LATENCY 3); out_resp 0 elsewhere.
//  add 0xFFFFFFFF + 0x00000001 -> resp 2, data 0; sub 0x3 - 0x4 -> resp 2, data 0; sub 0x9 - 0x9 -> resp 1, data 0.
//  shl 0x00000001 by 0x00000023 (count 3) -> 0x00000008; shr 0x80000000 by 31 -> 0x00000001; both resp 1.
//  cmd 4 with any operands -> resp 3, data 0 at T+4; next add accepted the cycle after the response.
//  Second add driven at T+2 -> ignored, cmd_dropped pulses once at T+3, only one response returned.
//  Reset pulsed low at T+2 of a pending add -> all outputs 0 at once, no response; fresh command served normally.

Source files
------------

// File: rtl/calc1_port_responder.sv
// Responder side of one calc1 request/response port: takes a command and two
// 32-bit operands, returns one response code and result word LATENCY cycles later.
module calc1_port_responder #(
    parameter int LATENCY = 3
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  req_cmd_in,
    input  logic [0:31] req_data_in,
    output logic [0:1]  out_resp,
    output logic [0:31] out_data,
    output logic        busy,
    output logic        cmd_dropped
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
        $error("calc1_port_responder: LATENCY must be within 1..15");
    end

    localparam logic [0:3] CMD_NOP = 4'd0;
    localparam logic [0:3] CMD_ADD = 4'd1;
    localparam logic [0:3] CMD_SUB = 4'd2;
    localparam logic [0:3] CMD_SHL = 4'd5;
    localparam logic [0:3] CMD_SHR = 4'd6;

    localparam logic [0:1] RESP_OK  = 2'd1;
    localparam logic [0:1] RESP_OVF = 2'd2;
    localparam logic [0:1] RESP_INV = 2'd3;

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OP2,
        S_EXEC,
        S_RESP
    } state_t;

    state_t      state;
    logic [0:3]  cmd_q;
    logic [3:0]  lat_cnt;
    logic [0:31] op1_p0;
    logic [0:31] op2_p0;

    // Packs {resp, data}; overflow and invalid commands always force data to zero.
    function automatic logic [0:33] calc_result(input logic [0:3]  cmd,
                                                input logic [0:31] a,
                                                input logic [0:31] b);
        logic [0:32] sum;
        sum = {1'b0, a} + {1'b0, b};
        case (cmd)
            CMD_ADD: calc_result = sum[0] ? {RESP_OVF, 32'd0} : {RESP_OK, sum[1:32]};
            CMD_SUB: calc_result = (b > a) ? {RESP_OVF, 32'd0} : {RESP_OK, a - b};
            CMD_SHL: calc_result = {RESP_OK, a << b[27:31]};
            CMD_SHR: calc_result = {RESP_OK, a >> b[27:31]};
            default: calc_result = {RESP_INV, 32'd0};
        endcase
    endfunction

    // Operand capture: op1 on command acceptance, op2 on the following data cycle.
    always_ff @(posedge c_clk) begin
        if (state == S_IDLE && req_cmd_in != CMD_NOP)
            op1_p0 <= req_data_in;
        if (state == S_OP2)
            op2_p0 <= req_data_in;
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cmd_q       <= CMD_NOP;
            lat_cnt     <= 4'd0;
            out_resp    <= 2'd0;
            out_data    <= 32'd0;
            busy        <= 1'b0;
            cmd_dropped <= 1'b0;
        end else begin
            out_resp    <= 2'd0;
            out_data    <= 32'd0;
            cmd_dropped <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_cmd_in != CMD_NOP) begin
                        cmd_q <= req_cmd_in;
                        busy  <= 1'b1;
                        state <= S_OP2;
                    end
                end
                S_OP2: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    cmd_dropped <= (req_cmd_in != CMD_NOP);
                    if (lat_cnt == 4'd0) begin
                        {out_resp, out_data} <= calc_result(cmd_q, op1_p0, op2_p0);
                        state <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    cmd_dropped <= (req_cmd_in != CMD_NOP);
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_port_responder.sv
// Bench for calc1_port_responder: directed literal cases plus random traffic
// compared every cycle against a transaction-age model of the port.
module tb_calc1_port_responder;

    localparam int LATENCY = 3;

    logic        c_clk = 1'b0;
    logic        reset;
    logic [0:3]  req_cmd_in;
    logic [0:31] req_data_in;
    logic [0:1]  out_resp;
    logic [0:31] out_data;
    logic        busy;
    logic        cmd_dropped;

    int n_cmp = 0;
    int n_err = 0;

    calc1_port_responder #(.LATENCY(LATENCY)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .busy        (busy),
        .cmd_dropped (cmd_dropped)
    );

    always #5 c_clk = ~c_clk;

    function automatic void check(input string nm, input logic [33:0] act, input logic [33:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Result of one operation as {resp[1:0], data[31:0]}.
    function automatic logic [33:0] model_calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        case (c)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                model_calc = s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
            end
            4'd2: model_calc = (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
            4'd5: model_calc = {2'd1, a << b[4:0]};
            4'd6: model_calc = {2'd1, a >> b[4:0]};
            default: model_calc = {2'd3, 32'd0};
        endcase
    endfunction

    // Model: age = edges since acceptance (-1 idle); response when age reaches LATENCY+1.
    int          age    = -1;
    logic [3:0]  m_cmd  = '0;
    logic [31:0] m_op1  = '0;
    logic [31:0] m_op2  = '0;
    logic [1:0]  e_resp = '0;
    logic [31:0] e_data = '0;
    logic        e_busy = 1'b0;
    logic        e_drop = 1'b0;

    always @(posedge c_clk or negedge reset) begin : model
        int          nxt;
        logic [33:0] r;
        if (!reset) begin
            age    <= -1;
            e_resp <= '0;
            e_data <= '0;
            e_busy <= 1'b0;
            e_drop <= 1'b0;
        end else begin
            nxt = age;
            r   = '0;
            if (age < 0) begin
                if (req_cmd_in != 4'd0) begin
                    nxt = 0;
                    m_cmd <= req_cmd_in;
                    m_op1 <= req_data_in;
                end
            end else begin
                if (age == 0) m_op2 <= req_data_in;
                nxt = (age == LATENCY + 1) ? -1 : age + 1;
                if (nxt == LATENCY + 1) r = model_calc(m_cmd, m_op1, m_op2);
            end
            age    <= nxt;
            e_resp <= r[33:32];
            e_data <= r[31:0];
            e_busy <= (nxt >= 0);
            e_drop <= (age >= 1) && (req_cmd_in != 4'd0);
        end
    end

    always @(negedge c_clk) begin
        check("out_resp",    34'(out_resp),    34'(e_resp));
        check("out_data",    34'(out_data),    34'(e_data));
        check("busy",        34'(busy),        34'(e_busy));
        check("cmd_dropped", 34'(cmd_dropped), 34'(e_drop));
    end

    task automatic txn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] xr, input logic [31:0] xd, input string nm);
        int k;
        @(negedge c_clk); req_cmd_in = c;    req_data_in = a;
        @(negedge c_clk); req_cmd_in = 4'd0; req_data_in = b;
        @(negedge c_clk); req_data_in = '0;  k = 1;
        while (out_resp == 2'd0 && k < 20) begin
            @(negedge c_clk);
            k++;
        end
        check({nm, "_latency"}, 34'(k), 34'(LATENCY + 1));
        check({nm, "_resp"}, 34'(out_resp), 34'(xr));
        check({nm, "_data"}, 34'(out_data), 34'(xd));
    endtask

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 3))
            0:       pick_data = 32'hFFFF_FFFF - $urandom_range(0, 3);
            1:       pick_data = $urandom_range(0, 40);
            default: pick_data = $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int resp_seen;
        reset = 1'b0;
        req_cmd_in = '0;
        req_data_in = '0;
        repeat (2) @(negedge c_clk);
        check("rst_resp",  34'(out_resp),    34'd0);
        check("rst_data",  34'(out_data),    34'd0);
        check("rst_busy",  34'(busy),        34'd0);
        check("rst_drop",  34'(cmd_dropped), 34'd0);
        reset = 1'b1;

        check("model_add", model_calc(4'd1, 32'h5, 32'h7), {2'd1, 32'h0000_000C});
        check("model_shl", model_calc(4'd5, 32'h1, 32'h23), {2'd1, 32'h0000_0008});
        check("model_sub", model_calc(4'd2, 32'h3, 32'h4), {2'd2, 32'h0});

        txn(4'd1, 32'h0000_0005, 32'h0000_0007, 2'd1, 32'h0000_000C, "add_basic");
        txn(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0,         "add_ovf");
        txn(4'd2, 32'h3,         32'h4,         2'd2, 32'h0,         "sub_unf");
        txn(4'd2, 32'h9,         32'h9,         2'd1, 32'h0,         "sub_eq");
        txn(4'd5, 32'h1,         32'h23,        2'd1, 32'h8,         "shl");
        txn(4'd6, 32'h8000_0000, 32'd31,        2'd1, 32'h1,         "shr");
        txn(4'd4, 32'h1234_5678, 32'h9ABC_DEF0, 2'd3, 32'h0,         "invalid");
        txn(4'd1, 32'h0000_0005, 32'h0000_0007, 2'd1, 32'h0000_000C, "add_after_inv");

        // Dropped command while executing; nonzero cmd in the data cycle is not flagged.
        @(negedge c_clk); req_cmd_in = 4'd1; req_data_in = 32'd10;
        @(negedge c_clk); req_cmd_in = 4'd7; req_data_in = 32'd20;
        @(negedge c_clk); req_cmd_in = 4'd1; req_data_in = 32'd99;
        check("op2_noflag", 34'(cmd_dropped), 34'd0);
        @(negedge c_clk); req_cmd_in = 4'd0; req_data_in = '0;
        check("drop_pulse", 34'(cmd_dropped), 34'd1);
        check("drop_busy",  34'(busy),        34'd1);
        @(negedge c_clk);
        check("drop_once",  34'(cmd_dropped), 34'd0);
        resp_seen = 0;
        repeat (10) begin
            if (out_resp != 2'd0) begin
                resp_seen++;
                check("drop_resp_data", 34'(out_data), 34'd30);
            end
            @(negedge c_clk);
        end
        check("drop_one_resp", 34'(resp_seen), 34'd1);

        // Reset in the middle of a pending add.
        @(negedge c_clk); req_cmd_in = 4'd1; req_data_in = 32'd100;
        @(negedge c_clk); req_cmd_in = 4'd0; req_data_in = 32'd200;
        @(negedge c_clk); req_data_in = '0;
        #2 reset = 1'b0;
        #1;
        check("midrst_resp", 34'(out_resp),    34'd0);
        check("midrst_data", 34'(out_data),    34'd0);
        check("midrst_busy", 34'(busy),        34'd0);
        check("midrst_drop", 34'(cmd_dropped), 34'd0);
        @(negedge c_clk); reset = 1'b1;
        resp_seen = 0;
        repeat (LATENCY + 4) begin
            @(negedge c_clk);
            if (out_resp != 2'd0) resp_seen++;
        end
        check("midrst_no_resp", 34'(resp_seen), 34'd0);
        txn(4'd1, 32'd1, 32'd2, 2'd1, 32'd3, "add_after_rst");

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge c_clk);
            req_cmd_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            req_data_in = pick_data();
        end
        @(negedge c_clk); req_cmd_in = '0; req_data_in = '0;
        repeat (LATENCY + 4) @(negedge c_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
